// File: rtl/cv32e40x_div_radix.sv
// Iterative restoring divider/remainder for the EX stage: K quotient bits per cycle, WIDTH-bit operands.
// Latency 1+N cycles (N from divisor magnitude) or 1+WIDTH/K when data-independent timing is requested.
package cv32e40x_div_radix_pkg;
    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_opcode_e;
endpackage

module cv32e40x_div_radix
    import cv32e40x_div_radix_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  div_opcode_e      operator_i,
    input  logic             data_ind_timing_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int K  = BITS_PER_CYCLE;
    localparam int KL = (K == 4) ? 2 : ((K == 2) ? 1 : 0);
    localparam int DW = WIDTH + K - 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ITERS = CW'(WIDTH / K);

    typedef enum logic [1:0] {IDLE, DIVIDE, DUMMY, FINISH} state_e;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    n_iter_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [DW-1:0]    dvs_q;
    logic             is_rem;
    logic             neg_quo;
    logic             neg_rem;
    logic             dit_q;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [CW-1:0]    lz;
    logic [CW-1:0]    n_iter;
    logic [DW-1:0]    dvs_init;
    logic [WIDTH-1:0] rem_nxt;
    logic [K-1:0]     qbits;
    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;

    assign signed_op = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
    assign a_neg     = signed_op & op_a_i[WIDTH-1];
    assign b_neg     = signed_op & op_b_i[WIDTH-1];
    assign abs_a     = a_neg ? -op_a_i : op_a_i;
    assign abs_b     = b_neg ? -op_b_i : op_b_i;

    // A zero divisor counts as WIDTH-1 leading zeros, giving a full-length run of ones.
    always_comb begin
        lz = CW'(WIDTH - 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (abs_b[i]) lz = CW'(WIDTH - 1 - i);
        end
    end

    assign n_iter   = CW'((int'(lz) + K) >> KL);
    assign dvs_init = DW'(abs_b) << ((int'(n_iter) << KL) - 1);

    always_comb begin
        logic [WIDTH-1:0] r;
        logic [DW-1:0]    d;
        r     = rem_q;
        d     = dvs_q;
        qbits = '0;
        for (int j = K - 1; j >= 0; j--) begin
            if (DW'(r) >= d) begin
                r        = WIDTH'(DW'(r) - d);
                qbits[j] = 1'b1;
            end
            d = d >> 1;
        end
        rem_nxt = r;
    end

    assign quo_res  = neg_quo ? -quo_q : quo_q;
    assign rem_res  = neg_rem ? -rem_q : rem_q;
    assign result_o = is_rem ? rem_res : quo_res;
    assign valid_o  = valid_i && (state == FINISH);
    assign ready_o  = !valid_i || ((state == FINISH) && ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            n_iter_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem   <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            dit_q    <= 1'b0;
        end else if (!valid_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    rem_q    <= abs_a;
                    quo_q    <= '0;
                    dvs_q    <= dvs_init;
                    cnt      <= n_iter - CW'(1);
                    n_iter_q <= n_iter;
                    is_rem   <= (operator_i == DIV_REM) || (operator_i == DIV_REMU);
                    neg_quo  <= (a_neg ^ b_neg) && (op_b_i != '0);
                    neg_rem  <= a_neg;
                    dit_q    <= data_ind_timing_i;
                    state    <= DIVIDE;
                end
                DIVIDE: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[WIDTH-K-1:0], qbits};
                    dvs_q <= dvs_q >> K;
                    if (cnt == '0) begin
                        // Pad short divisions out to the full WIDTH/K cycles when timing must not leak.
                        if (dit_q && (n_iter_q < ITERS)) begin
                            cnt   <= ITERS - n_iter_q - CW'(1);
                            state <= DUMMY;
                        end else begin
                            state <= FINISH;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DUMMY: begin
                    if (cnt == '0) state <= FINISH;
                    else           cnt   <= cnt - CW'(1);
                end
                FINISH: begin
                    if (ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e40x_div_radix.sv
// Drives six divider instances (WIDTH 32/16 x K 1/2/4) with shared ops; checks result and latency against an arithmetic model.
module tb_cv32e40x_div_radix;
    import cv32e40x_div_radix_pkg::*;

    localparam int NI = 6;
    localparam logic [NI-1:0] ALL = '1;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    div_opcode_e          op    = DIV_DIV;
    logic                 dit   = 1'b0;
    logic                 vld   = 1'b0;
    logic                 rdy_i = 1'b0;
    logic [31:0]          a     = '0;
    logic [31:0]          b     = '0;
    logic [NI-1:0]        vo;
    logic [NI-1:0]        ro;
    logic [NI-1:0][31:0]  res;
    int                   cyc      = 0;
    int                   checks   = 0;
    int                   failures = 0;
    int                   last_lat [NI];
    logic [31:0]          last_res [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g < 3) ? 32 : 16;
        logic [W-1:0] r;
        cv32e40x_div_radix #(.WIDTH(W), .BITS_PER_CYCLE(1 << (g % 3))) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .operator_i        (op),
            .data_ind_timing_i (dit),
            .op_a_i            (a[W-1:0]),
            .op_b_i            (b[W-1:0]),
            .valid_i           (vld),
            .ready_o           (ro[g]),
            .ready_i           (rdy_i),
            .valid_o           (vo[g]),
            .result_o          (r)
        );
        assign res[g] = 32'(r);
    end

    function automatic int wof(int g);
        return (g < 3) ? 32 : 16;
    endfunction

    function automatic int kof(int g);
        return 1 << (g % 3);
    endfunction

    function automatic logic [31:0] ref_res(int w, div_opcode_e o, logic [31:0] ai, logic [31:0] bi);
        longint m, ua, ub, sa, sb, r;
        m  = (longint'(1) << w) - 1;
        ua = longint'(ai) & m;
        ub = longint'(bi) & m;
        sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
        if (ub == 0) begin
            r = (o == DIV_DIV || o == DIV_DIVU) ? m : ua;
        end else begin
            case (o)
                DIV_DIVU: r = ua / ub;
                DIV_REMU: r = ua % ub;
                DIV_DIV:  r = sa / sb;
                default:  r = sa % sb;
            endcase
        end
        return 32'(r & m);
    endfunction

    function automatic int lat_exp(int w, int k, div_opcode_e o, logic [31:0] bi, logic d);
        longint m, ub;
        int     msb, s, n;
        m  = (longint'(1) << w) - 1;
        ub = longint'(bi) & m;
        if ((o == DIV_DIV || o == DIV_REM) && ub[w-1]) ub = (longint'(1) << w) - ub;
        msb = -1;
        for (int i = 0; i < w; i++) if (ub[i]) msb = i;
        s = (msb < 0) ? w - 1 : w - 1 - msb;
        n = (s + k) / k;
        return d ? (w / k + 1) : (n + 1);
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'hFFFF8000;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with every instance in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_op(input div_opcode_e o, input logic [31:0] ai, input logic [31:0] bi,
                          input logic d, input int kill_at, input int stall);
        int            c;
        int            lat [NI];
        logic [NI-1:0] done;
        op = o; a = ai; b = bi; dit = d; vld = 1'b1; rdy_i = 1'b0;
        c = cyc;
        #1;
        chk("accept_rdy", 32'(ro), 32'(0));
        done = '0;
        for (int g = 0; g < NI; g++) lat[g] = -1;
        for (int t = 1; t <= 40 && done != ALL; t++) begin
            @(negedge clk);
            if (t == kill_at) begin
                vld = 1'b0;
                #1;
                chk("kill_rdy", 32'(ro), 32'(ALL));
                chk("kill_vld", 32'(vo), 32'(0));
                @(negedge clk);
                return;
            end
            if (t == 1) begin
                op  = div_opcode_e'($urandom_range(0, 3));
                a   = $urandom;
                b   = $urandom;
                dit = 1'($urandom_range(0, 1));
            end
            chk("vo_hold", 32'(vo & done), 32'(done));
            for (int g = 0; g < NI; g++) begin
                if (!done[g] && vo[g]) begin
                    done[g] = 1'b1;
                    lat[g]  = cyc - c;
                end
            end
        end
        for (int g = 0; g < NI; g++) begin
            last_lat[g] = lat[g];
            last_res[g] = res[g];
            chk($sformatf("lat%0d", g), 32'(lat[g]), 32'(lat_exp(wof(g), kof(g), o, bi, d)));
            chk($sformatf("res%0d", g), res[g], ref_res(wof(g), o, ai, bi));
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_vld", 32'(vo), 32'(ALL));
            chk("stall_rdy", 32'(ro), 32'(0));
            for (int g = 0; g < NI; g++)
                chk($sformatf("stall_res%0d", g), res[g], ref_res(wof(g), o, ai, bi));
        end
        rdy_i = 1'b1;
        #1;
        chk("hs_rdy", 32'(ro), 32'(ALL));
        @(negedge clk);
        rdy_i = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_vld", 32'(vo), 32'(0));
        chk("rst_rdy", 32'(ro), 32'(ALL));
        for (int g = 0; g < NI; g++) chk($sformatf("rst_res%0d", g), res[g], 32'(0));
        vld = 1'b1;
        #1;
        chk("rst_rdy_vld", 32'(ro), 32'(0));
        vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(DIV_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 0);
        chk("div_m7_2", last_res[0], 32'hFFFFFFFD);
        run_op(DIV_REM, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 0);
        chk("rem_m7_2", last_res[0], 32'hFFFFFFFF);
        run_op(DIV_DIVU, 32'd100, 32'd7, 1'b0, 0, 0);
        chk("divu_100_7", last_res[0], 32'd14);
        run_op(DIV_REMU, 32'd100, 32'd7, 1'b0, 0, 0);
        chk("remu_100_7", last_res[0], 32'd2);
        run_op(DIV_DIVU, 32'd100, 32'd0, 1'b0, 0, 0);
        chk("divu_by0", last_res[0], 32'hFFFFFFFF);
        run_op(DIV_DIV, 32'hFFFFFFFB, 32'd0, 1'b0, 0, 0);
        chk("div_by0", last_res[0], 32'hFFFFFFFF);
        run_op(DIV_REM, 32'hFFFFFFFB, 32'd0, 1'b0, 0, 0);
        chk("rem_by0", last_res[0], 32'hFFFFFFFB);
        run_op(DIV_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0);
        chk("div_ovf", last_res[0], 32'h80000000);
        run_op(DIV_REM, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0);
        chk("rem_ovf", last_res[0], 32'h0);

        run_op(DIV_DIVU, 32'hFFFFFFFF, 32'd1, 1'b0, 0, 0);
        chk("lat_long_k1", 32'(last_lat[0]), 32'd33);
        chk("lat_long_k2", 32'(last_lat[1]), 32'd17);
        chk("lat_long_k4", 32'(last_lat[2]), 32'd9);
        chk("res_long", last_res[0], 32'hFFFFFFFF);
        run_op(DIV_DIVU, 32'd5, 32'h80000000, 1'b0, 0, 0);
        chk("lat_short_k1", 32'(last_lat[0]), 32'd2);
        chk("res_short", last_res[0], 32'h0);
        run_op(DIV_DIVU, 32'hFFFFFFFF, 32'd1, 1'b1, 0, 0);
        chk("lat_dit_long", 32'(last_lat[0]), 32'd33);
        run_op(DIV_DIVU, 32'd5, 32'h80000000, 1'b1, 0, 0);
        chk("lat_dit_short", 32'(last_lat[0]), 32'd33);

        run_op(DIV_DIVU, 32'hFFFFFFFF, 32'd1, 1'b1, 5, 0);
        run_op(DIV_DIV, 32'd100, 32'hFFFFFFFD, 1'b0, 0, 0);
        chk("kill_next_res", last_res[0], 32'hFFFFFFDF);
        chk("kill_next_lat", 32'(last_lat[0]), 32'd32);

        run_op(DIV_REMU, 32'd12345, 32'd77, 1'b0, 0, 3);

        op = DIV_DIVU; a = 32'hFFFFFFFF; b = 32'd1; dit = 1'b1; vld = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(vo), 32'(0));
        chk("mid_rst_rdy", 32'(ro), 32'(0));
        for (int g = 0; g < NI; g++) chk($sformatf("mid_rst_res%0d", g), res[g], 32'(0));
        vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_vld", 32'(vo), 32'(0));
        chk("post_rst_rdy", 32'(ro), 32'(ALL));
        for (int g = 0; g < NI; g++) chk($sformatf("post_rst_res%0d", g), res[g], 32'(0));

        for (int i = 0; i < 700; i++) begin
            div_opcode_e o;
            logic [31:0] ra, rb;
            int          ka;
            o  = div_opcode_e'($urandom_range(0, 3));
            ra = rnd_opnd();
            rb = rnd_opnd();
            ka = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_op(o, ra, rb, 1'($urandom_range(0, 1)), ka, int'($urandom_range(0, 3)));
        end
        vld = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
